// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
//
// LIFO operand store for the push/add stack calculator. It sits directly
// downstream of the calculator controller: the controller raises a push and/or
// pop request level, the stack acts on it in its IDLE state and answers with
// one-cycle completion pulses that advance the controller FSM.
//
// Handshake: a request is evaluated on every rising edge while the FSM is in
// IDLE. Any evaluated request, accepted or rejected, moves the FSM to ACK for
// exactly one cycle. The completion pulses (o_pushed / o_poped) are high during
// that ACK cycle only when the operation actually took place. Requests are
// ignored in ACK. A request still held in the IDLE cycle after ACK is evaluated
// again, so the controller must drop its request when it sees the pulse.
//
// Ports
//   clk            in   1      system clock, all state on rising edge
//   rst_n          in   1      asynchronous active-low reset
//   din            in   WIDTH  data to push, sampled on the accepting edge
//   i_push         in   1      push request (level)
//   i_pop          in   1      pop request (level)
//   dout           out  WIDTH  last popped value, held until next good pop
//   o_pushed       out  1      one-cycle pulse: push completed
//   o_poped        out  1      one-cycle pulse: pop completed, dout valid
//   o_full         out  1      stack_pointer == DEPTH
//   o_empty        out  1      stack_pointer == 0
//   o_error        out  1      sticky overflow/underflow flag, reset clears
//   stack_pointer  out  SP_W   number of valid entries
//   o_fsm_state    out  1      debug view of the FSM (0 = IDLE, 1 = ACK)
// -----------------------------------------------------------------------------
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [WIDTH-1:0] dout,
    output logic             o_pushed,
    output logic             o_poped,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_error,
    output logic [SP_W-1:0]  stack_pointer,
    output logic             o_fsm_state
);

    // Address width of the storage array; DEPTH is a power of two.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] SP_EMPTY = '0;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [SP_W-1:0]    r_sp;
    logic [WIDTH-1:0]   r_dout;
    logic               r_pushed;
    logic               r_poped;
    logic               r_error;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    state_t             w_next_state;
    logic               w_full;
    logic               w_empty;
    logic               w_do_push;   // write at sp, sp+1
    logic               w_do_pop;    // read at sp-1, sp-1
    logic               w_do_swap;   // read and overwrite at sp-1, sp unchanged
    logic               w_set_error;
    logic [AW-1:0]      w_sp_addr;   // slot just above the top entry
    logic [AW-1:0]      w_top_addr;  // current top entry

    assign w_full  = (r_sp == SP_FULL);
    assign w_empty = (r_sp == SP_EMPTY);

    // When the stack is full the low bits of sp wrap to 0, and 0 - 1 lands on
    // the last slot, which is exactly the top entry. A push is never performed
    // while full, so w_sp_addr is only used when it is in range.
    assign w_sp_addr  = r_sp[AW-1:0];
    assign w_top_addr = w_sp_addr - AW'(1);

    always_comb begin
        w_next_state = r_state;
        w_do_push    = 1'b0;
        w_do_pop     = 1'b0;
        w_do_swap    = 1'b0;
        w_set_error  = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_push && i_pop) begin
                    w_next_state = ACK;
                    // Swap on an empty stack degenerates to a plain push;
                    // there is nothing to return, and it is not an error.
                    if (w_empty) begin
                        w_do_push = 1'b1;
                    end else begin
                        w_do_swap = 1'b1;
                    end
                end else if (i_push) begin
                    w_next_state = ACK;
                    if (w_full) begin
                        w_set_error = 1'b1;
                    end else begin
                        w_do_push = 1'b1;
                    end
                end else if (i_pop) begin
                    w_next_state = ACK;
                    if (w_empty) begin
                        w_set_error = 1'b1;
                    end else begin
                        w_do_pop = 1'b1;
                    end
                end
            end
            ACK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sp     <= '0;
            r_dout   <= '0;
            r_pushed <= 1'b0;
            r_poped  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Pulses are rewritten every edge, so they last exactly the one
            // ACK cycle following the accepting edge.
            r_pushed <= w_do_push | w_do_swap;
            r_poped  <= w_do_pop  | w_do_swap;

            if (w_do_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_do_pop) begin
                r_sp <= r_sp - SP_W'(1);
            end

            if (w_do_pop || w_do_swap) begin
                r_dout <= r_mem[w_top_addr];
            end

            if (w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage array. Contents are don't-care after reset, so no reset here.
    // On a swap the read above sees the old top value because both updates
    // happen on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_sp_addr] <= din;
        end else if (w_do_swap) begin
            r_mem[w_top_addr] <= din;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dout          = r_dout;
    assign o_pushed      = r_pushed;
    assign o_poped       = r_poped;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_error       = r_error;
    assign stack_pointer = r_sp;
    assign o_fsm_state   = r_state;

endmodule
